mem_initiator: RTL and testbench

- Initiator (master) end of the single-cycle valid/ready memory interface: drives clk-synchronous write and read requests into a memory responder.
- On a start pulse it performs a fill-and-check pass. It writes an address-derived pattern to every location, reads every location back, compares against the expected value, and reports pass/fail, error count and first failing address.
- Used as a built-in self-test engine in front of the memory block.

---
 rtl/mem_initiator_if.sv | 15 +
 rtl/mem_initiator.sv | 194 +++++++++++++++++++
 tb/tb_mem_initiator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
// Single-cycle valid/ready memory request bus between the BIST initiator and the memory responder.
interface mem_initiator_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (output valid, wr_rd, addr, wdata, input  rdata, ready);
  modport slave  (input  valid, wr_rd, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_initiator.sv
// Memory BIST initiator: writes seed+addr to every location, reads each back and compares.
// Optional macro MEM_INIT_TIMEOUT_EN aborts a pass when ready is missing for TIMEOUT cycles.
module mem_initiator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  mem_initiator_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  timeout
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [CW-1:0]         err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic                  pass_q, pass_d;
  logic                  tout_q, tout_d;
  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_addr;
  logic [WIDTH-1:0]      expected;

  assign last_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign expected  = seed_q + WIDTH'(addr_q);

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    tout_d  = tout_q;
`ifdef MEM_INIT_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          addr_d  = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          tout_d  = 1'b0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        state_d = WR_WAIT;
`ifdef MEM_INIT_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WR_WAIT: begin
        if (bus.ready) begin
          if (last_addr) begin
            addr_d  = '0;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = WR_REQ;
          end
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT)) begin
          tout_d  = 1'b1;
          state_d = FINISH;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`endif
      end
      RD_REQ: begin
        state_d = RD_WAIT;
`ifdef MEM_INIT_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      RD_WAIT: begin
        if (bus.ready) begin
          if (bus.rdata != expected) begin
            if (err_q != CW'(DEPTH)) err_d = err_q + CW'(1);
            if (err_q == '0)         fail_d = addr_q;
          end
          if (last_addr) begin
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = RD_REQ;
          end
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT)) begin
          tout_d  = 1'b1;
          state_d = FINISH;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`endif
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result is resolved on entry to FINISH so pass is already valid while done pulses.
    if (state_d == FINISH && state_q != FINISH) pass_d = (err_d == '0) && !tout_d;

    // Bus and status outputs are decoded from the next state so they leave flops directly.
    valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    wr_rd_d = (state_d == WR_REQ) || (state_d == WR_WAIT);
    wdata_d = wr_rd_d ? (seed_d + WIDTH'(addr_d)) : '0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
      valid_q <= 1'b0;
      wr_rd_q <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
      wr_rd_q <= wr_rd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_INIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!res) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end
`endif

  assign bus.valid = valid_q;
  assign bus.wr_rd = wr_rd_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;
  assign timeout   = tout_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: behavioural responder, request scoreboard, result checks.
module tb_mem_initiator;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 15;

  logic            clk   = 1'b0;
  logic            res   = 1'b0;
  logic            start = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic            busy, done, pass, timeout;
  logic [AW:0]     err_count;
  logic [AW-1:0]   fail_addr;

  mem_initiator_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  mem_initiator #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .res(res), .start(start), .seed(seed), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder: registered ready one cycle after valid; per-address read corruption mask.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] corrupt [DEPTH];
  bit               stuck = 1'b0;

  always @(posedge clk) begin
    if (!res) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else if (bus.valid && !stuck) begin
      bus.ready <= 1'b1;
      if (bus.wr_rd) mem[bus.addr] <= bus.wdata;
      bus.rdata <= bus.wr_rd ? '0 : (mem[bus.addr] ^ corrupt[bus.addr]);
    end else begin
      bus.ready <= 1'b0;
    end
  end

  typedef struct packed {
    logic             wr;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } req_t;

  req_t sb[$];
  req_t mon_e;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.valid) begin
      check("valid_one_cycle", 32'(prev_valid), 0);
      check("sb_avail", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("req_wr_rd", 32'(bus.wr_rd), 32'(mon_e.wr));
        check("req_addr",  32'(bus.addr),  32'(mon_e.a));
        check("req_wdata", 32'(bus.wdata), 32'(mon_e.d));
      end
    end
    prev_valid <= bus.valid;
  end

  task automatic push_pass(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] sum;
    for (int a = 0; a < DEPTH; a++) begin
      sum = s + WIDTH'(a);
      sb.push_back('{wr: 1'b1, a: AW'(a), d: sum});
    end
    for (int a = 0; a < DEPTH; a++) sb.push_back('{wr: 1'b0, a: AW'(a), d: '0});
  endtask

  // cycles counts the start cycle as 1 and the done cycle inclusively.
  task automatic run_pass(input logic [WIDTH-1:0] s, input int restart_n);
    int cycles;
    bit done_seen;
    int exp_err;
    int exp_fail;
    exp_err  = 0;
    exp_fail = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (corrupt[a] != '0) begin
        if (exp_err == 0) exp_fail = a;
        exp_err++;
      end
    end
    push_pass(s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles    = 1;
    done_seen = 1'b0;
    while (cycles < 200 && !done_seen) begin
      @(negedge clk);
      cycles++;
      if (cycles == restart_n) begin
        start = 1'b1;
        seed  = ~s;
      end else begin
        start = 1'b0;
      end
      if (cycles == 2) begin
        check("pass_cleared", 32'(pass), 0);
        check("err_cleared",  32'(err_count), 0);
        check("busy_started", 32'(busy), 1);
      end
      if (done) done_seen = 1'b1;
    end
    check("done_cycle", cycles, 4 * DEPTH + 2);
    check("pass",       32'(pass), 32'(exp_err == 0));
    check("err_count",  32'(err_count), exp_err);
    check("fail_addr",  32'(fail_addr), exp_fail);
    check("timeout",    32'(timeout), 0);
    check("sb_drained", sb.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("done_single", 32'(done), 0);
      check("busy_after",  32'(busy), 0);
    end
    check("pass_hold", 32'(pass), 32'(exp_err == 0));
    check("err_hold",  32'(err_count), exp_err);
  endtask

  initial begin
    int  n;
    int  n_valid;
    bit  seen;
    for (int a = 0; a < DEPTH; a++) corrupt[a] = '0;

    repeat (3) @(negedge clk);
    check("rst_valid",     32'(bus.valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_done",      32'(done), 0);
    check("rst_pass",      32'(pass), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_fail_addr", 32'(fail_addr), 0);
    check("rst_timeout",   32'(timeout), 0);
    res = 1'b1;
    @(negedge clk);

    run_pass(8'h00, -1);

    run_pass(8'hF8, -1);
    check("wrap_mem8",  32'(mem[8]),  32'h00);
    check("wrap_mem15", 32'(mem[15]), 32'h07);

    corrupt[5] = 8'h01;
    corrupt[9] = 8'h80;
    run_pass(8'h21, -1);
    corrupt[5] = '0;
    corrupt[9] = '0;

    // Reset during the write request for address 7.
    push_pass(8'h33);
    @(negedge clk);
    seed  = 8'h33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(bus.valid && bus.wr_rd && bus.addr == AW'(7))) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr7", 32'(n < 100), 1);
    res = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.valid), 0);
    check("rst_mid_busy",  32'(busy), 0);
    check("rst_mid_done",  32'(done), 0);
    res = 1'b1;
    sb.delete();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_rst", 32'(seen), 0);
    run_pass(8'h10, -1);

    run_pass(8'h5A, 20);

    // Responder never answers.
    stuck = 1'b1;
    push_pass(8'h00);
    @(negedge clk);
    seed  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    n       = 2;
    n_valid = 0;
    seen    = 1'b0;
    while (n < 120 && !seen) begin
      if (bus.valid && n_valid == 0) n_valid = n;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
`ifdef MEM_INIT_TIMEOUT_EN
    check("to_done_seen", 32'(seen), 1);
    check("to_latency",   n - n_valid, TIMEOUT + 2);
    check("to_flag",      32'(timeout), 1);
    check("to_pass",      32'(pass), 0);
`else
    check("stuck_no_done", 32'(seen), 0);
    check("stuck_busy",    32'(busy), 1);
    check("stuck_timeout", 32'(timeout), 0);
`endif
    res = 1'b0;
    repeat (2) @(negedge clk);
    stuck = 1'b0;
    sb.delete();
    check("final_rst_busy",    32'(busy), 0);
    check("final_rst_timeout", 32'(timeout), 0);
    res = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
